// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for uart_tx_arbiter.
// slave is the arbiter side; master is the requesters plus transmitter side.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_byte;
  logic [NUM_REQ-1:0]   ack;
  logic                 busy;
  logic                 err;
  logic                 tx_start;
  logic [7:0]           tx_byte;
  logic                 tx_ready;

  modport slave (
    input  req, req_byte, tx_ready,
    output ack, busy, err, tx_start, tx_byte
  );

  modport master (
    output req, req_byte, tx_ready,
    input  ack, busy, err, tx_start, tx_byte
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from NUM_REQ byte requesters,
// with a bounded wait for the transmitter to accept each start strobe.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned START_TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   ptr, ptr_next, winner;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               tx_start_q, tx_start_next;
  logic               err_q, err_next;
  logic [7:0]         tx_byte_q, tx_byte_next, sel_byte;
  logic [NUM_REQ-1:0] ack_q, ack_next;
  logic               found;
  logic [7:0]         bytes [NUM_REQ];
  int unsigned        idx;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign bytes[g] = bus.req_byte[8*g +: 8];
  end

  // First set request at or above ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found    = 1'b0;
    winner   = ptr;
    sel_byte = '0;
    idx      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req[PTR_W'(idx)]) begin
        found    = 1'b1;
        winner   = PTR_W'(idx);
        sel_byte = bytes[PTR_W'(idx)];
      end
    end
  end

  always_comb begin
    state_next    = state;
    ptr_next      = ptr;
    cnt_next      = cnt;
    tx_start_next = tx_start_q;
    tx_byte_next  = tx_byte_q;
    ack_next      = '0;
    err_next      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.tx_ready && found) begin
          tx_byte_next     = sel_byte;
          ack_next[winner] = 1'b1;
          tx_start_next    = 1'b1;
          ptr_next         = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          cnt_next         = '0;
          state_next       = START;
        end
      end
      START: begin
        if (!bus.tx_ready) begin
          tx_start_next = 1'b0;
          cnt_next      = '0;
          state_next    = WAIT_DONE;
        end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
          // Transmitter never took the strobe: drop the byte, no retry.
          tx_start_next = 1'b0;
          err_next      = 1'b1;
          state_next    = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (bus.tx_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      tx_start_q <= 1'b0;
      tx_byte_q  <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_next;
      ptr        <= ptr_next;
      cnt        <= cnt_next;
      tx_start_q <= tx_start_next;
      tx_byte_q  <= tx_byte_next;
      ack_q      <= ack_next;
      err_q      <= err_next;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.busy     = (state != IDLE);
  assign bus.err      = err_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_byte  = tx_byte_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with NUM_REQ=4 and a transmitter model
// whose tx_ready falls 4 cycles after the start strobe and stays low 6 cycles.
module tb_uart_tx_arbiter;
  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic model_en, man_ready, m_ready, m_active;
  int   m_cnt;
  int   fall_delay = 4;
  int   frame_len  = 6;

  assign bus.tx_ready = model_en ? m_ready : man_ready;

  // Transmitter model, updated on the falling edge to stay clear of DUT sampling.
  always @(negedge clk) begin
    if (!model_en) begin
      m_ready  = 1'b1;
      m_active = 1'b0;
      m_cnt    = 0;
    end else if (!m_active) begin
      if (bus.tx_start) begin
        m_active = 1'b1;
        m_cnt    = 0;
      end
    end else begin
      m_cnt++;
      if (m_cnt == fall_delay) m_ready = 1'b0;
      else if (m_cnt == fall_delay + frame_len) begin
        m_ready  = 1'b1;
        m_active = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic model_after);
    model_en = 1'b0;
    rst_n    = 1'b0;
    step();
    step();
    rst_n    = 1'b1;
    model_en = model_after;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; model_en = 1'b0; man_ready = 1'b0;
    bus.req = '0; bus.req_byte = '0;
    step();
    step();
    total_cnt++;
    if ({bus.ack, bus.busy, bus.err, bus.tx_start} !== 7'b0)
      $display("FAIL reset_ctl: got %b want 0000000", {bus.ack, bus.busy, bus.err, bus.tx_start});
    else pass_cnt++;
    total_cnt++;
    if (bus.tx_byte !== 8'h00) $display("FAIL reset_byte: got %h want 00", bus.tx_byte);
    else pass_cnt++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    int starts, steps, hold_bad, ack_extra;
    model_en = 1'b1;
    step();
    bus.req_byte = {8'h00, 8'h00, 8'h00, 8'h55};
    bus.req      = 4'b0001;
    step();
    total_cnt++;
    if (bus.ack !== 4'b0001) $display("FAIL single_ack: got %b want 0001", bus.ack);
    else pass_cnt++;
    total_cnt++;
    if (bus.tx_start !== 1'b1) $display("FAIL single_start: got %b want 1", bus.tx_start);
    else pass_cnt++;
    total_cnt++;
    if (bus.tx_byte !== 8'h55) $display("FAIL single_byte: got %h want 55", bus.tx_byte);
    else pass_cnt++;
    bus.req = '0;
    starts = 1; steps = 0; hold_bad = 0; ack_extra = 0;
    while (bus.busy === 1'b1 && steps < 50) begin
      step();
      steps++;
      if (bus.tx_start === 1'b1) starts++;
      if (bus.busy === 1'b1 && bus.tx_byte !== 8'h55) hold_bad++;
      if (bus.ack !== 4'b0000) ack_extra++;
    end
    total_cnt++;
    if (steps != 11) $display("FAIL single_frame_len: got %0d want 11", steps);
    else pass_cnt++;
    total_cnt++;
    if (starts != 5) $display("FAIL single_start_cycles: got %0d want 5", starts);
    else pass_cnt++;
    total_cnt++;
    if (hold_bad != 0) $display("FAIL single_byte_hold: got %0d changes want 0", hold_bad);
    else pass_cnt++;
    total_cnt++;
    if (ack_extra != 0) $display("FAIL single_ack_pulse: got %0d extra want 0", ack_extra);
    else pass_cnt++;
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL single_idle: got busy=%b want 0", bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_contention();
    logic [3:0] exp_ack;
    logic [7:0] exp_byte;
    logic       got, saw_idle;
    int         pulse_bad, order_bad, overlap_bad;
    do_reset(1'b1);
    bus.req_byte = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.req      = 4'b1111;
    pulse_bad = 0; order_bad = 0; overlap_bad = 0; saw_idle = 1'b1;
    for (int g = 0; g < 5; g++) begin
      exp_ack  = 4'b0001 << (g % 4);
      exp_byte = 8'hA0 + 8'(g % 4);
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        step();
        if (bus.busy === 1'b0) saw_idle = 1'b1;
        if (bus.ack !== 4'b0000) got = 1'b1;
      end
      if (!got || bus.ack !== exp_ack || bus.tx_byte !== exp_byte) begin
        order_bad++;
        $display("FAIL contention_grant%0d: got ack=%b byte=%h want ack=%b byte=%h",
                 g, bus.ack, bus.tx_byte, exp_ack, exp_byte);
      end
      if (!saw_idle) overlap_bad++;
      saw_idle = 1'b0;
      step();
      if (bus.ack !== 4'b0000) pulse_bad++;
    end
    total_cnt++;
    if (order_bad != 0) $display("FAIL contention_order: got %0d bad grants want 0", order_bad);
    else pass_cnt++;
    total_cnt++;
    if (pulse_bad != 0) $display("FAIL contention_ack_pulse: got %0d long acks want 0", pulse_bad);
    else pass_cnt++;
    total_cnt++;
    if (overlap_bad != 0) $display("FAIL contention_one_frame: got %0d overlaps want 0", overlap_bad);
    else pass_cnt++;
    bus.req = '0;
    for (int c = 0; c < 40 && bus.busy === 1'b1; c++) step();
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL contention_drain: got busy=%b want 0", bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [4];
    logic       got;
    exp_seq[0] = 4'b0010; exp_seq[1] = 4'b1000; exp_seq[2] = 4'b0001; exp_seq[3] = 4'b0010;
    do_reset(1'b1);
    bus.req = 4'b0010;
    for (int g = 0; g < 4; g++) begin
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        step();
        if (bus.ack !== 4'b0000) got = 1'b1;
      end
      total_cnt++;
      if (!got || bus.ack !== exp_seq[g])
        $display("FAIL rr_grant%0d: got %b want %b", g, bus.ack, exp_seq[g]);
      else pass_cnt++;
      if (g == 0) begin
        bus.req = 4'b0000;
        for (int c = 0; c < 40 && bus.busy === 1'b1; c++) step();
        bus.req = 4'b1011;
      end
    end
    bus.req = '0;
    for (int c = 0; c < 40 && bus.busy === 1'b1; c++) step();
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL rr_drain: got busy=%b want 0", bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int starts, errs, acks, last_start, err_idx;
    logic busy_at_err;
    model_en = 1'b0; man_ready = 1'b1;
    bus.req  = 4'b0100;
    starts = 0; errs = 0; acks = 0; last_start = -1; err_idx = -1; busy_at_err = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.ack[2] === 1'b1) begin acks++; bus.req = '0; end
      if (bus.tx_start === 1'b1) begin starts++; last_start = i; end
      if (bus.err === 1'b1) begin errs++; err_idx = i; busy_at_err = bus.busy; end
    end
    total_cnt++;
    if (starts != 16) $display("FAIL timeout_start_cycles: got %0d want 16", starts);
    else pass_cnt++;
    total_cnt++;
    if (errs != 1) $display("FAIL timeout_err_pulses: got %0d want 1", errs);
    else pass_cnt++;
    total_cnt++;
    if (acks != 1) $display("FAIL timeout_acks: got %0d want 1", acks);
    else pass_cnt++;
    total_cnt++;
    if (err_idx != last_start + 1) $display("FAIL timeout_err_time: got %0d want %0d", err_idx, last_start + 1);
    else pass_cnt++;
    total_cnt++;
    if (busy_at_err !== 1'b0) $display("FAIL timeout_busy: got %b want 0", busy_at_err);
    else pass_cnt++;
  endtask

  task automatic test_not_ready();
    int bad;
    model_en = 1'b0; man_ready = 1'b0;
    bus.req = 4'b0010;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.ack !== 4'b0000 || bus.tx_start !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL notready_hold: got %0d grant cycles want 0", bad);
    else pass_cnt++;
    model_en = 1'b1;
    step();
    total_cnt++;
    if (bus.ack !== 4'b0010 || bus.tx_start !== 1'b1)
      $display("FAIL notready_grant: got ack=%b start=%b want ack=0010 start=1", bus.ack, bus.tx_start);
    else pass_cnt++;
    bus.req = '0;
    for (int c = 0; c < 40 && bus.busy === 1'b1; c++) step();
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL notready_drain: got busy=%b want 0", bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    int bad;
    logic got;
    model_en = 1'b1;
    bus.req_byte = {8'h00, 8'h00, 8'h00, 8'h3C};
    bus.req = 4'b0001;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      step();
      if (bus.ack !== 4'b0000) got = 1'b1;
    end
    bus.req = '0;
    for (int c = 0; c < 40 && !(bus.busy === 1'b1 && bus.tx_start === 1'b0); c++) step();
    total_cnt++;
    if (!got || bus.busy !== 1'b1 || bus.tx_start !== 1'b0)
      $display("FAIL midrst_reach_wait: got busy=%b start=%b want busy=1 start=0", bus.busy, bus.tx_start);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.ack, bus.busy, bus.err, bus.tx_start, bus.tx_byte} !== 15'b0)
      $display("FAIL midrst_immediate: got %h want 0", {bus.ack, bus.busy, bus.err, bus.tx_start, bus.tx_byte});
    else pass_cnt++;
    model_en = 1'b0; man_ready = 1'b0;
    bus.req = 4'b0001;
    step();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.ack !== 4'b0000 || bus.tx_start !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL midrst_no_grant: got %0d active cycles want 0", bad);
    else pass_cnt++;
    man_ready = 1'b1;
    step();
    total_cnt++;
    if (bus.ack !== 4'b0001 || bus.tx_byte !== 8'h3C)
      $display("FAIL midrst_regrant: got ack=%b byte=%h want ack=0001 byte=3c", bus.ack, bus.tx_byte);
    else pass_cnt++;
    bus.req = '0;
    man_ready = 1'b0;
    step();
    step();
    man_ready = 1'b1;
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_round_robin();
    test_timeout();
    test_not_ready();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
